// File: rtl/key_conditioner.sv
// key_conditioner
//
// Multi-channel push-button front end. Each raw key is synchronised, normalised so that
// 1 means pressed, and debounced. The block then produces a clean level, single-cycle
// press/release pulses, and an optional auto-repeat pulse train for held keys.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   keys_i       raw key pins (asynchronous to clk_i)
//   repeat_en_i  per-channel auto-repeat enable
//   state_o      debounced level, 1 = pressed
//   press_o      one-cycle pulse when state_o rises
//   release_o    one-cycle pulse when state_o falls
//   repeat_o     one-cycle pulse on press and on every auto-repeat
//
// All outputs are registered; there is no combinational path from any input to any output.

module key_conditioner #(
  parameter int unsigned N_KEYS               = 2,
  parameter bit          ACTIVE_LOW           = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES      = 500_000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 15_000_000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 2_500_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] keys_i,
  input  logic [N_KEYS-1:0] repeat_en_i,
  output logic [N_KEYS-1:0] state_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] repeat_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  // Terminal counts: the event fires on the edge where the counter would reach the target.
  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD_CYCLES - 1);

  // Raw level of a released key; the synchronisers reset to it so reset never looks like a press.
  localparam logic RelLevel = ACTIVE_LOW;

  typedef enum logic {
    StWaitDelay,
    StWaitPeriod
  } phase_e;

  for (genvar k = 0; k < int'(N_KEYS); k++) begin : g_chan
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            pressed_now;
    logic            stable_q, stable_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            rise, fall;
    phase_e          phase_q, phase_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_due;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync1_q   <= RelLevel;
        sync2_q   <= RelLevel;
        stable_q  <= 1'b0;
        db_cnt_q  <= '0;
        phase_q   <= StWaitDelay;
        rpt_cnt_q <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        phase_q   <= phase_d;
        rpt_cnt_q <= rpt_cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    // Next state: synchroniser, debounce and auto-repeat schedule.
    always_comb begin
      sync1_d     = keys_i[k];
      sync2_d     = sync1_q;
      pressed_now = sync2_q ^ ACTIVE_LOW;

      stable_d = stable_q;
      db_cnt_d = '0;
      rise     = 1'b0;
      fall     = 1'b0;
      // Any sample that agrees with the accepted level is a bounce and restarts the count.
      if (pressed_now != stable_q) begin
        if (db_cnt_q == DbLast) begin
          stable_d = ~stable_q;
          rise     = ~stable_q;
          fall     = stable_q;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end

      rpt_cnt_d = rpt_cnt_q;
      phase_d   = phase_q;
      // Press, release, idle or a disabled channel all restart the schedule from the delay
      // phase; release therefore also suppresses a repeat that falls due on the same edge.
      if (rise || fall || !stable_q || !repeat_en_i[k]) begin
        rpt_cnt_d = '0;
        phase_d   = StWaitDelay;
      end else begin
        unique case (phase_q)
          StWaitDelay: begin
            if (rpt_cnt_q == DelayLast) begin
              rpt_cnt_d = '0;
              phase_d   = StWaitPeriod;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RptW'(1);
            end
          end
          StWaitPeriod: begin
            if (rpt_cnt_q == PeriodLast) begin
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RptW'(1);
            end
          end
          default: begin
            rpt_cnt_d = '0;
            phase_d   = StWaitDelay;
          end
        endcase
      end
    end

    // Output decode: next values of the registered pulses.
    always_comb begin
      rpt_due = 1'b0;
      unique case (phase_q)
        StWaitDelay:  rpt_due = (rpt_cnt_q == DelayLast);
        StWaitPeriod: rpt_due = (rpt_cnt_q == PeriodLast);
        default:      rpt_due = 1'b0;
      endcase
      press_d   = rise;
      release_d = fall;
      repeat_d  = rise | (stable_q & ~fall & repeat_en_i[k] & rpt_due);
    end

    assign state_o[k]   = stable_q;
    assign press_o[k]   = press_q;
    assign release_o[k] = release_q;
    assign repeat_o[k]  = repeat_q;
  end

endmodule
